// File: rtl/univ_shift_reg.sv
// Universal shift register: shifts, rotates, load and clear.
// Counts shift operations since the last load and flags a full word.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [2:0] M_HLD = 3'b000;
  localparam logic [2:0] M_SHL = 3'b001;
  localparam logic [2:0] M_SHR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [2:0] M_LD  = 3'b101;
  localparam logic [2:0] M_ASR = 3'b110;
  localparam logic [2:0] M_CLR = 3'b111;

  localparam logic [CW-1:0] CMAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             sh;
  logic             rld;

  always_comb begin
    q_nxt = q;
    sh    = 1'b0;
    rld   = 1'b0;
    unique case (mode)
      M_HLD: q_nxt = q;
      M_SHL: begin
        q_nxt = {q[WIDTH-2:0], sin_r};
        sh    = 1'b1;
      end
      M_SHR: begin
        q_nxt = {sin_l, q[WIDTH-1:1]};
        sh    = 1'b1;
      end
      M_ROL: begin
        q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        sh    = 1'b1;
      end
      M_ROR: begin
        q_nxt = {q[0], q[WIDTH-1:1]};
        sh    = 1'b1;
      end
      M_LD: begin
        q_nxt = d;
        rld   = 1'b1;
      end
      M_ASR: begin
        q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
        sh    = 1'b1;
      end
      M_CLR: begin
        q_nxt = '0;
        rld   = 1'b1;
      end
      default: q_nxt = q;
    endcase
  end

  // done fires only on the WIDTH-1 -> WIDTH step, never while saturated
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!enable) begin
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      done <= sh && (cnt == CLAST);
      if (rld)
        cnt <= '0;
      else if (sh && (cnt < CMAX))
        cnt <= cnt + CW'(1);
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed vector bench for univ_shift_reg (WIDTH=8, RESET_VAL=A5).
module tb_univ_shift_reg;

  localparam logic [2:0] HLD = 3'd0;
  localparam logic [2:0] SHL = 3'd1;
  localparam logic [2:0] SHR = 3'd2;
  localparam logic [2:0] ROL = 3'd3;
  localparam logic [2:0] ROR = 3'd4;
  localparam logic [2:0] LD  = 3'd5;
  localparam logic [2:0] ASR = 3'd6;
  localparam logic [2:0] CLR = 3'd7;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] cnt;
  logic       done;

  int tests = 0;
  int fails = 0;
  vec_t tv[$];

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q),
    .sout_l(sout_l), .sout_r(sout_r), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic en,
                     input logic [2:0] md, input logic [7:0] dd,
                     input logic sl, input logic sr,
                     input logic [7:0] eq, input logic [3:0] ec,
                     input logic ed);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = md; v.d = dd;
    v.sl = sl; v.sr = sr; v.q = eq; v.cnt = ec; v.done = ed;
    tv.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; enable = v.en; mode = v.mode;
    d = v.d; sin_l = v.sl; sin_r = v.sr;
    @(posedge clk);
    #1;
    tests++;
    if (q !== v.q) begin
      fails++;
      $display("FAIL q[%0d]: got %h want %h", idx, q, v.q);
    end
    tests++;
    if (cnt !== v.cnt) begin
      fails++;
      $display("FAIL cnt[%0d]: got %0d want %0d", idx, cnt, v.cnt);
    end
    tests++;
    if (done !== v.done) begin
      fails++;
      $display("FAIL done[%0d]: got %b want %b", idx, done, v.done);
    end
    tests++;
    if (sout_l !== v.q[7] || sout_r !== v.q[0]) begin
      fails++;
      $display("FAIL sout[%0d]: got %b%b want %b%b",
               idx, sout_l, sout_r, v.q[7], v.q[0]);
    end
  endtask

  initial begin
    vec_t h;
    // reset wins over load, then load on first free edge
    add(1, 1, LD,  8'hFF, 0, 0, 8'hA5, 0, 0);
    add(0, 1, LD,  8'hFF, 0, 0, 8'hFF, 0, 0);
    // serialise 96 out of the MSB, filling with ones
    add(0, 1, LD,  8'h96, 0, 0, 8'h96, 0, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h2D, 1, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h5B, 2, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hB7, 3, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h6F, 4, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hDF, 5, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hBF, 6, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h7F, 7, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hFF, 8, 1);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hFF, 8, 0);
    // rotates, arithmetic and logical right shifts
    add(0, 1, LD,  8'h81, 0, 0, 8'h81, 0, 0);
    add(0, 1, ROL, 8'h00, 0, 0, 8'h03, 1, 0);
    add(0, 1, ROR, 8'h00, 0, 0, 8'h81, 2, 0);
    add(0, 1, ROR, 8'h00, 0, 0, 8'hC0, 3, 0);
    add(0, 1, LD,  8'h80, 0, 0, 8'h80, 0, 0);
    add(0, 1, ASR, 8'h00, 0, 0, 8'hC0, 1, 0);
    add(0, 1, ASR, 8'h00, 0, 0, 8'hE0, 2, 0);
    add(0, 1, ASR, 8'h00, 0, 0, 8'hF0, 3, 0);
    add(0, 1, LD,  8'h80, 0, 0, 8'h80, 0, 0);
    add(0, 1, SHR, 8'h00, 0, 0, 8'h40, 1, 0);
    add(0, 1, SHR, 8'h00, 1, 0, 8'hA0, 2, 0);
    // hold mode leaves q and cnt alone
    add(0, 1, HLD, 8'h00, 1, 1, 8'hA0, 2, 0);
    // enable drop mid-word freezes state
    add(0, 1, LD,  8'h96, 0, 0, 8'h96, 0, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'h2C, 1, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'h58, 2, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'hB0, 3, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, SHL, 8'h00, 0, 1, 8'hB0, 3, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'h60, 4, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'hC0, 5, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'h80, 6, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'h00, 7, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'h00, 8, 1);
    // clear while done is high, then hold
    add(0, 1, CLR, 8'hFF, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, HLD, 8'hFF, 1, 1, 8'h00, 0, 0);
    // reset on the 8th shift cancels the pending done
    add(0, 1, LD,  8'h3C, 0, 0, 8'h3C, 0, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h79, 1, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hF3, 2, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hE7, 3, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'hCF, 4, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h9F, 5, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h3F, 6, 0);
    add(0, 1, SHL, 8'h00, 0, 1, 8'h7F, 7, 0);
    add(1, 1, SHL, 8'h00, 0, 1, 8'hA5, 0, 0);
    add(0, 1, SHL, 8'h00, 0, 0, 8'h4A, 1, 0);

    for (int i = 0; i < tv.size(); i++)
      apply(tv[i], i);

    // full rotate-right word, then enable drop clears done
    h = '{rst:0, en:1, mode:LD, d:8'h01, sl:0, sr:0,
          q:8'h01, cnt:0, done:0};
    apply(h, 100);
    for (int i = 1; i <= 8; i++) begin
      h.mode = ROR;
      h.q    = {h.q[0], h.q[7:1]};
      h.cnt  = 4'(i);
      h.done = (i == 8);
      apply(h, 100 + i);
    end
    h.en = 0; h.done = 0;
    apply(h, 109);
    // reset with enable low still resets
    h.rst = 1; h.q = 8'hA5; h.cnt = 0;
    apply(h, 110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: a WIDTH-bit register with clock enable, synchronous reset and eight operating modes (hold, logical/arithmetic shifts, rotates, parallel load, clear). It generalises the single-bit enable flip-flop into the team's standard storage/serialisation element for parallel-to-serial and serial-to-parallel paths. It also tracks the shift operations performed since the last load and pulses a completion flag when a full word has been shifted.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q by RESET
- CW, $clog2(WIDTH+1), width of CNT (derived, not overridden)

Ports:
- CLK  input  1  single clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- ENABLE  input  1  clock enable, active-high
- MODE  input  3  operation select (see Operation)
- D  input  WIDTH  parallel load data
- SIN_L  input  1  serial input entering at MSB (shift right)
- SIN_R  input  1  serial input entering at LSB (shift left)
- Q  output  WIDTH  register contents
- SOUT_L  output  1  Q[WIDTH-1], combinational from Q
- SOUT_R  output  1  Q[0], combinational from Q
- CNT  output  CW  shift/rotate operations since last load/clear/reset, saturating at WIDTH
- DONE  output  1  one-cycle pulse: CNT has just reached WIDTH

## Operation
- Priority: RESET > ENABLE > MODE.
- RESET=1 at an edge: Q←RESET_VAL, CNT←0, DONE←0, regardless of ENABLE/MODE.
- ENABLE=0: Q and CNT hold; DONE←0.
- ENABLE=1, by MODE:
  - 000 hold: Q holds, CNT holds.
  - 001 shift left: Q←{Q[WIDTH-2:0], SIN_R}.
  - 010 shift right: Q←{SIN_L, Q[WIDTH-1:1]}.
  - 011 rotate left: Q←{Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 100 rotate right: Q←{Q[0], Q[WIDTH-1:1]}.
  - 101 parallel load: Q←D, CNT←0.
  - 110 arithmetic shift right: Q←{Q[WIDTH-1], Q[WIDTH-1:1]}.
  - 111 clear: Q←0 (not RESET_VAL), CNT←0.
- Shift-class modes are 001, 010, 011, 100 and 110. Each enabled shift-class cycle: if CNT<WIDTH then CNT←CNT+1, else CNT holds at WIDTH (saturate, no wrap).
- DONE←1 exactly on the edge where CNT goes from WIDTH-1 to WIDTH; DONE←0 on every other edge, including further shifts while saturated.
- Load/clear while DONE=1: DONE←0, CNT←0.
- Mixed shift directions all count identically. CNT measures operations, not net displacement.

## Timing
- All outputs registered except SOUT_L/SOUT_R, which are wires from Q (valid same cycle as Q).
- Latency: one clock from input sampling to Q/CNT/DONE update.
- DONE is high for exactly one cycle, coincident with CNT first showing WIDTH.
- After reset deassertion, the first active edge performs the selected operation; no dead cycles.
- Reset mid-operation (CNT in 1..WIDTH-1): next edge gives CNT=0 and DONE=0. No pending DONE survives.
- ENABLE dropped mid-serialisation: CNT frozen and resumes counting when ENABLE returns. DONE still fires once at the WIDTH-th shift.
- Unknown/X MODE is not required to be handled. Each of the 8 encodings is defined.

## Test plan
- Reset with RESET_VAL=8'hA5, MODE=101, D=8'hFF, ENABLE=1 → Q=8'hA5, CNT=0, DONE=0. Then release RESET: next edge Q=8'hFF.
- Load 8'b1001_0110, then 8 cycles of MODE=001 with SIN_R=1 → SOUT_L sequence 1,0,0,1,0,1,1,0 and final Q=8'hFF. CNT counts 1..8. DONE=1 only in the cycle CNT=8. A 9th shift keeps CNT=8 with DONE=0.
- Load 8'h81, then MODE=011 ×1 → 8'h03; MODE=100 ×2 → 8'hC0. Load 8'h80, then MODE=110 ×3 → 8'hF0. Load 8'h80, then MODE=010 with SIN_L=0 → 8'h40.
- Load, shift 3 times, deassert ENABLE for 4 cycles while MODE=001 → Q and CNT (=3) unchanged, DONE=0. Re-enable for 5 shifts → DONE pulses on the 5th.
- Load, shift 7 times (CNT=7), assert RESET on the 8th shift cycle → Q=RESET_VAL, CNT=0, DONE never asserted.
- With CNT=8 and DONE=1, apply MODE=111 → Q=0, CNT=0, DONE=0. Then MODE=000 for 3 cycles → all outputs hold.
